// File: rtl/led_pattern_engine_pkg.sv
// Shared mode/direction types and seed helper for the LED pattern engine.
package led_pattern_engine_pkg;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'b00,
    MODE_MARQ  = 2'b01,
    MODE_PING  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Blink seed bit: even positions lit, so the LSB is always 1.
  function automatic logic alt_bit(input int idx);
    return ((idx % 32'sd2) == 32'sd0) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/led_pattern_engine_prescaler.sv
// Step-rate prescaler: emits a combinational step pulse every DIV_MAX enabled clocks.
module clk_prescaler #(
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV_MAX - 1);
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;

  // Next count: clear wins, then wrap at the last count, frozen while disabled.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (en) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign step = en & ~clr & (cnt_r == CNT_LAST);

endmodule

// File: rtl/led_pattern_engine.sv
// Four-mode LED pattern generator (count, marquee, ping-pong, blink) at a prescaled rate.
module led_pattern_engine
  import led_pattern_engine_pkg::*;
#(
  parameter int LED_W   = 8,
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       choose,
  input  logic             en,
  output logic [LED_W-1:0] LED,
  output logic             tick,
  output logic [1:0]       mode_q
);

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  mode_e            mode_r, mode_nxt_s, choose_s;
  dir_e             dir_r, dir_nxt_s;
  logic [LED_W-1:0] led_r, led_nxt_s;
  logic             tick_r, tick_nxt_s;
  logic             mode_change_s;
  logic             step_s;

  function automatic logic [LED_W-1:0] seed_of(input mode_e m);
    logic [LED_W-1:0] s;
    s = '0;
    case (m)
      MODE_CNT:   s = '0;
      MODE_MARQ:  s = LED_ONE;
      MODE_PING:  s = LED_ONE;
      MODE_BLINK: for (int i = 0; i < LED_W; i++) s[i] = alt_bit(i);
      default:    s = '0;
    endcase
    return s;
  endfunction

  assign choose_s      = mode_e'(choose);
  assign mode_change_s = (choose_s != mode_r);

  clk_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (mode_change_s),
    .step (step_s)
  );

  // Next state: a mode change reseeds and suppresses any coincident step.
  always_comb begin
    mode_nxt_s = mode_r;
    led_nxt_s  = led_r;
    dir_nxt_s  = dir_r;
    tick_nxt_s = 1'b0;
    if (mode_change_s) begin
      mode_nxt_s = choose_s;
      led_nxt_s  = seed_of(choose_s);
      dir_nxt_s  = DIR_UP;
    end else if (step_s) begin
      tick_nxt_s = 1'b1;
      case (mode_r)
        MODE_CNT:   led_nxt_s = led_r + LED_ONE;
        MODE_MARQ:  led_nxt_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
        MODE_PING: begin
          // Bounce off either end immediately so end positions never repeat.
          if (dir_r == DIR_UP) begin
            if (led_r[LED_W-1]) begin
              led_nxt_s = {1'b0, led_r[LED_W-1:1]};
              dir_nxt_s = DIR_DOWN;
            end else begin
              led_nxt_s = {led_r[LED_W-2:0], 1'b0};
            end
          end else begin
            if (led_r[0]) begin
              led_nxt_s = {led_r[LED_W-2:0], 1'b0};
              dir_nxt_s = DIR_UP;
            end else begin
              led_nxt_s = {1'b0, led_r[LED_W-1:1]};
            end
          end
        end
        MODE_BLINK: led_nxt_s = ~led_r;
        default:    led_nxt_s = led_r;
      endcase
    end else begin
      tick_nxt_s = 1'b0;
    end
  end

  // Mode, pattern, direction and tick registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r <= MODE_CNT;
      led_r  <= '0;
      dir_r  <= DIR_UP;
      tick_r <= 1'b0;
    end else begin
      mode_r <= mode_nxt_s;
      led_r  <= led_nxt_s;
      dir_r  <= dir_nxt_s;
      tick_r <= tick_nxt_s;
    end
  end

  assign LED    = led_r;
  assign tick   = tick_r;
  assign mode_q = mode_r;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed self-checking bench for led_pattern_engine (LED_W=8, DIV_MAX=4).
module tb_led_pattern_engine;

  logic       clk;
  logic       rst;
  logic [1:0] choose;
  logic       en;
  logic [7:0] led;
  logic       tick;
  logic [1:0] mode_q;

  int errors = 0;
  int checks = 0;

  logic [7:0] marq_exp [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] ping_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] blink_exp [3] = '{8'hAA, 8'h55, 8'hAA};

  led_pattern_engine #(
    .LED_W   (8),
    .DIV_W   (24),
    .DIV_MAX (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .choose (choose),
    .en     (en),
    .LED    (led),
    .tick   (tick),
    .mode_q (mode_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n80;
    int n01;
    rst    = 1'b0;
    choose = 2'b00;
    en     = 1'b1;
    #2;
    chk("rst_led", led, 8'h00);
    chk("rst_tick", {7'd0, tick}, 8'h00);
    chk("rst_mode", {6'd0, mode_q}, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // 1: counter mode, one step every 4 clocks, then wrap
    clk_n(3);
    chk("cnt_pre_led", led, 8'h00);
    chk("cnt_pre_tick", {7'd0, tick}, 8'h00);
    clk_n(1);
    chk("cnt_s1_led", led, 8'h01);
    chk("cnt_s1_tick", {7'd0, tick}, 8'h01);
    clk_n(1);
    chk("cnt_s1_tick_off", {7'd0, tick}, 8'h00);
    chk("cnt_s1_hold", led, 8'h01);
    clk_n(3);
    chk("cnt_s2_led", led, 8'h02);
    chk("cnt_s2_tick", {7'd0, tick}, 8'h01);
    clk_n(4);
    chk("cnt_s3_led", led, 8'h03);
    clk_n(1008);
    chk("cnt_ff_led", led, 8'hFF);
    clk_n(4);
    chk("cnt_wrap_led", led, 8'h00);
    chk("cnt_wrap_tick", {7'd0, tick}, 8'h01);

    // 2: marquee
    choose = 2'b01;
    clk_n(1);
    chk("marq_seed", led, 8'h01);
    chk("marq_mode", {6'd0, mode_q}, 8'h01);
    chk("marq_seed_tick", {7'd0, tick}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      clk_n(4);
      chk($sformatf("marq_step%0d", i), led, marq_exp[i]);
      chk($sformatf("marq_tick%0d", i), {7'd0, tick}, 8'h01);
    end

    // 3: ping-pong, ends visited once per sweep
    choose = 2'b10;
    clk_n(1);
    chk("ping_seed", led, 8'h01);
    chk("ping_mode", {6'd0, mode_q}, 8'h02);
    n80 = 0;
    n01 = 0;
    for (int i = 0; i < 15; i++) begin
      clk_n(4);
      chk($sformatf("ping_step%0d", i), led, ping_exp[i]);
      chk($sformatf("ping_tick%0d", i), {7'd0, tick}, 8'h01);
      if (i < 14 && led == 8'h80) n80++;
      if (i < 14 && led == 8'h01) n01++;
    end
    chk("ping_count_80", 8'(n80), 8'd1);
    chk("ping_count_01", 8'(n01), 8'd1);

    // 4: blink, then a mode change on the exact step cycle
    choose = 2'b11;
    clk_n(1);
    chk("blink_seed", led, 8'h55);
    chk("blink_mode", {6'd0, mode_q}, 8'h03);
    for (int i = 0; i < 3; i++) begin
      clk_n(4);
      chk($sformatf("blink_step%0d", i), led, blink_exp[i]);
    end
    clk_n(3);
    chk("blink_pre_led", led, 8'hAA);
    chk("blink_pre_tick", {7'd0, tick}, 8'h00);
    choose = 2'b00;
    clk_n(1);
    chk("override_led", led, 8'h00);
    chk("override_tick", {7'd0, tick}, 8'h00);
    chk("override_mode", {6'd0, mode_q}, 8'h00);
    clk_n(4);
    chk("override_next_led", led, 8'h01);
    chk("override_next_tick", {7'd0, tick}, 8'h01);

    // 5: pause mid-count; resume finishes only the remaining count
    clk_n(2);
    chk("pause_pre_led", led, 8'h01);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_n(1);
      chk($sformatf("pause_led%0d", i), led, 8'h01);
      chk($sformatf("pause_tick%0d", i), {7'd0, tick}, 8'h00);
    end
    en = 1'b1;
    clk_n(1);
    chk("resume1_led", led, 8'h01);
    chk("resume1_tick", {7'd0, tick}, 8'h00);
    clk_n(1);
    chk("resume2_led", led, 8'h02);
    chk("resume2_tick", {7'd0, tick}, 8'h01);

    // 6: async reset between edges during ping-pong, release into blink
    choose = 2'b10;
    clk_n(1);
    chk("ping2_seed", led, 8'h01);
    clk_n(4);
    chk("ping2_step", led, 8'h02);
    chk("ping2_tick", {7'd0, tick}, 8'h01);
    #2;
    rst = 1'b0;
    #1;
    chk("async_led", led, 8'h00);
    chk("async_mode", {6'd0, mode_q}, 8'h00);
    chk("async_tick", {7'd0, tick}, 8'h00);
    choose = 2'b11;
    @(negedge clk);
    chk("held_rst_led", led, 8'h00);
    rst = 1'b1;
    clk_n(1);
    chk("rel_led", led, 8'h55);
    chk("rel_mode", {6'd0, mode_q}, 8'h03);
    chk("rel_tick", {7'd0, tick}, 8'h00);
    clk_n(4);
    chk("rel_step_led", led, 8'hAA);
    chk("rel_step_tick", {7'd0, tick}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
